// File: rtl/audio_step_sequencer.sv
// -----------------------------------------------------------------------------
// audio_step_sequencer
// Pattern player feeding the voice bank. Holds a STEPS x VOICES note table,
// advances one step every `tempo` sample ticks and drives per-voice note/gate.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   sample_clock sample-rate square wave (data input, rising edge = tick)
//   run          1 = play, 0 = stop (takes effect on any clk edge)
//   tempo        sample ticks per step
//   gate_len     sample ticks the gate stays high within a step
//   swing        (SEQ_SWING_EN only) even steps longer / odd steps shorter
//   loop_last    last step index before wrapping to 0
//   wr_en/wr_addr/wr_data  pattern write port, addr = {step, voice},
//                          data = {valid, note[6:0]}
//   note         per-voice note, lane v = bits [8v+7:8v]
//   gate         per-voice gate
//   step         currently playing step
//   step_strobe  one-clk pulse when a new step is loaded
//
// Optional feature macro: SEQ_SWING_EN (adds the swing input).
// -----------------------------------------------------------------------------
module audio_step_sequencer #(
    parameter int unsigned STEPS  = 16,
    parameter int unsigned VOICES = 4,
    parameter int unsigned AW     = $clog2(STEPS*VOICES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_clock,
    input  logic                       run,
    input  logic [15:0]                tempo,
    input  logic [15:0]                gate_len,
`ifdef SEQ_SWING_EN
    input  logic [7:0]                 swing,
`endif
    input  logic [$clog2(STEPS)-1:0]   loop_last,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [7:0]                 wr_data,
    output logic [8*VOICES-1:0]        note,
    output logic [VOICES-1:0]          gate,
    output logic [$clog2(STEPS)-1:0]   step,
    output logic                       step_strobe
);

    localparam int unsigned SW = $clog2(STEPS);
    localparam int unsigned VW = $clog2(VOICES);
    // 17 bits so that eff_tempo + swing cannot overflow
    localparam int unsigned CW = 17;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [7:0]          r_ram [STEPS*VOICES];
    logic                r_sc_d;
    logic [0:0]          r_state,  w_state_n;
    logic [CW-1:0]       r_cnt,    w_cnt_n;
    logic [SW-1:0]       r_step,   w_step_n;
    logic [8*VOICES-1:0] r_note,   w_note_n;
    logic [VOICES-1:0]   r_valid,  w_valid_n;
    logic [VOICES-1:0]   r_gate,   w_gate_n;
    logic                r_strobe, w_strobe_n;

    logic                w_tick;
    logic                w_load;
    logic [15:0]         w_eff_tempo;
    logic [SW-1:0]       w_load_step;
    logic [CW-1:0]       w_len_cur, w_len_new;
    logic [CW-1:0]       w_glim_cur, w_glim_new;
    logic [CW-1:0]       w_cnt_inc;
    logic [7:0]          w_row [VOICES];

    // Rising edge of sample_clock, sampled in the clk domain
    assign w_tick = sample_clock & ~r_sc_d;

    assign w_eff_tempo = (tempo < 16'd2) ? 16'd2 : tempo;
    assign w_cnt_inc   = r_cnt + CW'(1);

    // Step that a load on this edge would fetch: 0 from IDLE, else next/wrap
    assign w_load_step = (r_state == S_IDLE) ? '0 :
                         ((r_step >= loop_last) ? '0 : r_step + SW'(1));

`ifdef SEQ_SWING_EN
    function automatic logic [CW-1:0] step_len(input logic [15:0] t,
                                               input logic [7:0]  sw,
                                               input logic        odd);
        if (!odd)
            return CW'(t) + CW'(sw);
        else if (CW'(t) >= CW'(sw) + CW'(2))
            return CW'(t) - CW'(sw);
        else
            return CW'(2);
    endfunction

    assign w_len_cur = step_len(w_eff_tempo, swing, r_step[0]);
    assign w_len_new = step_len(w_eff_tempo, swing, w_load_step[0]);
`else
    assign w_len_cur = CW'(w_eff_tempo);
    assign w_len_new = CW'(w_eff_tempo);
`endif

    // Gate limit never exceeds length-1 so every step has a low tick
    function automatic logic [CW-1:0] gate_lim(input logic [15:0]   gl,
                                               input logic [CW-1:0] len);
        if (CW'(gl) < len - CW'(1))
            return CW'(gl);
        else
            return len - CW'(1);
    endfunction

    assign w_glim_cur = gate_lim(gate_len, w_len_cur);
    assign w_glim_new = gate_lim(gate_len, w_len_new);

    // Combinational read of the row being loaded
    for (genvar v = 0; v < VOICES; v++) begin : g_row
        assign w_row[v] = r_ram[AW'({w_load_step, VW'(v)})];
    end

    // Pattern RAM write port (not reset)
    always_ff @(posedge clk) begin
        if (wr_en)
            r_ram[wr_addr] <= wr_data;
    end

    // Next-state and output logic
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_step_n   = r_step;
        w_note_n   = r_note;
        w_valid_n  = r_valid;
        w_gate_n   = r_gate;
        w_strobe_n = 1'b0;
        w_load     = 1'b0;

        if (!run) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_step_n  = '0;
            w_gate_n  = '0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: w_load = 1'b1;
                S_PLAY: begin
                    // >= so a shortened tempo advances on the next tick
                    if (r_cnt >= w_len_cur - CW'(1)) begin
                        w_load = 1'b1;
                    end else begin
                        w_cnt_n  = w_cnt_inc;
                        w_gate_n = r_valid & {VOICES{w_cnt_inc < w_glim_cur}};
                    end
                end
                default: w_state_n = S_IDLE;
            endcase

            if (w_load) begin
                w_state_n  = S_PLAY;
                w_cnt_n    = '0;
                w_step_n   = w_load_step;
                w_strobe_n = 1'b1;
                for (int v = 0; v < VOICES; v++) begin
                    w_valid_n[v] = w_row[v][7];
                    w_gate_n[v]  = w_row[v][7] & (w_glim_new != '0);
                    if (w_row[v][7])
                        w_note_n[8*v +: 8] = {1'b0, w_row[v][6:0]};
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc_d   <= 1'b0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_step   <= '0;
            r_note   <= '0;
            r_valid  <= '0;
            r_gate   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sc_d   <= sample_clock;
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_step   <= w_step_n;
            r_note   <= w_note_n;
            r_valid  <= w_valid_n;
            r_gate   <= w_gate_n;
            r_strobe <= w_strobe_n;
        end
    end

    assign note        = r_note;
    assign gate        = r_gate;
    assign step        = r_step;
    assign step_strobe = r_strobe;

endmodule
